// File: rtl/hdc_pkg.sv
// Shared constants and scorer state encoding for the HDC inference scorer.
package hdc_pkg;

    localparam int HDC_CLASS_COUNT = 26;
    localparam int HDC_LABEL_W     = 5;
    localparam int HDC_CNT_W       = 16;
    // Accuracy quotient bits: one integer bit plus eight fraction bits.
    localparam int HDC_ACC_W       = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCORE = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } scorer_state_e;

endpackage

// File: rtl/hdc_acc_divider.sv
// Restoring divider producing q = floor(dividend * 256 / divisor) in 9 steps.
// Requires dividend <= divisor and divisor != 0; the first quotient bit is
// the integer bit. start_i loads operands, done_o pulses with q_o valid.
module hdc_acc_divider
    import hdc_pkg::*;
#(
    parameter int W = HDC_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic [W-1:0]         dividend_i,
    input  logic [W-1:0]         divisor_i,
    output logic                 done_o,
    output logic [HDC_ACC_W-1:0] q_o
);

    // Remainder stays below 2*divisor, so one extra bit is enough.
    logic [W:0]           r_q;
    logic [W-1:0]         d_q;
    logic [HDC_ACC_W-1:0] q_q;
    logic [3:0]           cnt_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 q_bit;
    logic [W:0]           r_d;

    assign q_bit = (r_q >= {1'b0, d_q});
    // Subtract when the bit is set, then shift; the shifted-out MSB is always 0.
    assign r_d   = (q_bit ? (r_q - {1'b0, d_q}) : r_q) << 1;

    // Load on start, then one quotient bit per enabled cycle.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_q    <= '0;
            d_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (en_i) begin
            done_q <= 1'b0;
            if (start_i) begin
                r_q    <= {1'b0, dividend_i};
                d_q    <= divisor_i;
                q_q    <= '0;
                cnt_q  <= 4'(HDC_ACC_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                r_q   <= r_d;
                q_q   <= {q_q[HDC_ACC_W-2:0], q_bit};
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign q_o    = q_q;

endmodule

// File: rtl/hdc_inference_scorer.sv
// Scores HDC classifier inferences against ground-truth labels, keeping
// saturating total/correct counts and computing an 8-bit fractional accuracy
// after the test set finishes.
// Optional per-class statistics: define HDC_PER_CLASS_STATS_EN to build
// per-class total/correct counters readable through rd_class.
module hdc_inference_scorer
    import hdc_pkg::*;
#(
    parameter int CLASS_COUNT = HDC_CLASS_COUNT,
    parameter int LABEL_W     = HDC_LABEL_W,
    parameter int CNT_W       = HDC_CNT_W
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 start_scoring,
    input  logic                 checking_inference,
    input  logic [LABEL_W-1:0]   class_inference,
    input  logic [LABEL_W-1:0]   true_label,
    input  logic                 testing_dataset_finished,
    input  logic [LABEL_W-1:0]   rd_class,
    output logic [CNT_W-1:0]     rd_total,
    output logic [CNT_W-1:0]     rd_correct,
    output logic [CNT_W-1:0]     total_count,
    output logic [CNT_W-1:0]     correct_count,
    output logic [HDC_ACC_W-1:0] accuracy_q8,
    output logic                 invalid_label,
    output logic                 cnt_saturated,
    output logic                 scoring_done
);

    localparam logic [LABEL_W:0] CLASS_LIM = (LABEL_W+1)'(CLASS_COUNT);

    scorer_state_e        state_q;
    logic [CNT_W-1:0]     total_q, correct_q;
    logic [CNT_W-1:0]     total_d, correct_d;
    logic [HDC_ACC_W-1:0] acc_q;
    logic                 invalid_q, sat_q, done_q;

    logic                 label_ok, hit;
    logic                 score_cyc, strobe_ok, strobe_bad;
    logic                 clear_go, div_start, div_done;
    logic [HDC_ACC_W-1:0] div_q;

    assign label_ok   = ({1'b0, true_label} < CLASS_LIM);
    assign hit        = (class_inference == true_label);
    // A start pulse in SCORE wins over any strobe or finish in the same cycle.
    assign score_cyc  = en && (state_q == SCORE) && !start_scoring;
    assign strobe_ok  = score_cyc && checking_inference && label_ok;
    assign strobe_bad = score_cyc && checking_inference && !label_ok;
    assign clear_go   = en && start_scoring && (state_q != DIV);

    // Next counts include a strobe coincident with the finish pulse.
    always_comb begin
        total_d   = total_q;
        correct_d = correct_q;
        if (strobe_ok && (total_q != '1))
            total_d = total_q + 1'b1;
        if (strobe_ok && hit && (correct_q != '1))
            correct_d = correct_q + 1'b1;
    end

    // Divider starts on the finish edge with the up-to-date counts.
    assign div_start = score_cyc && testing_dataset_finished && (total_d != '0);

    hdc_acc_divider #(
        .W (CNT_W)
    ) u_div (
        .clk_i      (clk),
        .nrst_i     (nrst),
        .en_i       (en),
        .start_i    (div_start),
        .dividend_i (correct_d),
        .divisor_i  (total_d),
        .done_o     (div_done),
        .q_o        (div_q)
    );

    // Scorer FSM with registered counters, flags and result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            total_q   <= '0;
            correct_q <= '0;
            acc_q     <= '0;
            invalid_q <= 1'b0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE, DONE, SCORE: begin
                    if (start_scoring) begin
                        state_q   <= SCORE;
                        total_q   <= '0;
                        correct_q <= '0;
                        acc_q     <= '0;
                        invalid_q <= 1'b0;
                        sat_q     <= 1'b0;
                        done_q    <= 1'b0;
                    end else if (state_q == SCORE) begin
                        total_q   <= total_d;
                        correct_q <= correct_d;
                        if (strobe_bad)
                            invalid_q <= 1'b1;
                        if ((&total_d) || (&correct_d))
                            sat_q <= 1'b1;
                        if (testing_dataset_finished) begin
                            if (total_d == '0) begin
                                acc_q   <= '0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                state_q <= DIV;
                            end
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        acc_q   <= div_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign total_count   = total_q;
    assign correct_count = correct_q;
    assign accuracy_q8   = acc_q;
    assign invalid_label = invalid_q;
    assign cnt_saturated = sat_q;
    assign scoring_done  = done_q;

`ifdef HDC_PER_CLASS_STATS_EN
    logic [CNT_W-1:0] pc_tot_q [CLASS_COUNT];
    logic [CNT_W-1:0] pc_cor_q [CLASS_COUNT];

    // Per-class counters follow the global counters' clear and saturation.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < CLASS_COUNT; i++) begin
                pc_tot_q[i] <= '0;
                pc_cor_q[i] <= '0;
            end
        end else if (clear_go) begin
            for (int i = 0; i < CLASS_COUNT; i++) begin
                pc_tot_q[i] <= '0;
                pc_cor_q[i] <= '0;
            end
        end else if (strobe_ok) begin
            for (int i = 0; i < CLASS_COUNT; i++) begin
                if (true_label == LABEL_W'(i)) begin
                    if (pc_tot_q[i] != '1)
                        pc_tot_q[i] <= pc_tot_q[i] + 1'b1;
                    if (hit && (pc_cor_q[i] != '1))
                        pc_cor_q[i] <= pc_cor_q[i] + 1'b1;
                end
            end
        end
    end

    // Readback mux; out-of-range selects fall through to zero.
    always_comb begin
        rd_total   = '0;
        rd_correct = '0;
        for (int i = 0; i < CLASS_COUNT; i++) begin
            if (rd_class == LABEL_W'(i)) begin
                rd_total   = pc_tot_q[i];
                rd_correct = pc_cor_q[i];
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd  = ^{rd_class, clear_go};
    assign rd_total   = '0;
    assign rd_correct = '0;
`endif

endmodule

// File: tb/tb_hdc_inference_scorer.sv
// Directed self-checking bench for hdc_inference_scorer. A second instance
// with CNT_W = 4 shares the stimulus and is checked for saturation.
module tb_hdc_inference_scorer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic        start_scoring;
    logic        checking_inference;
    logic [4:0]  class_inference;
    logic [4:0]  true_label;
    logic        testing_dataset_finished;
    logic [4:0]  rd_class;

    logic [15:0] rd_total, rd_correct, total_count, correct_count;
    logic [8:0]  accuracy_q8;
    logic        invalid_label, cnt_saturated, scoring_done;

    logic [3:0]  s_rd_total, s_rd_correct, s_total, s_correct;
    logic [8:0]  s_acc;
    logic        s_invalid, s_sat, s_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hdc_inference_scorer #(.CLASS_COUNT(26), .LABEL_W(5), .CNT_W(16)) dut (
        .clk                      (clk),
        .nrst                     (nrst),
        .en                       (en),
        .start_scoring            (start_scoring),
        .checking_inference       (checking_inference),
        .class_inference          (class_inference),
        .true_label               (true_label),
        .testing_dataset_finished (testing_dataset_finished),
        .rd_class                 (rd_class),
        .rd_total                 (rd_total),
        .rd_correct               (rd_correct),
        .total_count              (total_count),
        .correct_count            (correct_count),
        .accuracy_q8              (accuracy_q8),
        .invalid_label            (invalid_label),
        .cnt_saturated            (cnt_saturated),
        .scoring_done             (scoring_done)
    );

    hdc_inference_scorer #(.CLASS_COUNT(26), .LABEL_W(5), .CNT_W(4)) dut4 (
        .clk                      (clk),
        .nrst                     (nrst),
        .en                       (en),
        .start_scoring            (start_scoring),
        .checking_inference       (checking_inference),
        .class_inference          (class_inference),
        .true_label               (true_label),
        .testing_dataset_finished (testing_dataset_finished),
        .rd_class                 (rd_class),
        .rd_total                 (s_rd_total),
        .rd_correct               (s_rd_correct),
        .total_count              (s_total),
        .correct_count            (s_correct),
        .accuracy_q8              (s_acc),
        .invalid_label            (s_invalid),
        .cnt_saturated            (s_sat),
        .scoring_done             (s_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start_scoring = 1'b1;
        tick();
        start_scoring = 1'b0;
    endtask

    task automatic strobe(input logic [4:0] pred, input logic [4:0] lab);
        checking_inference = 1'b1;
        class_inference    = pred;
        true_label         = lab;
        tick();
        checking_inference = 1'b0;
    endtask

    // Finish pulse; optionally carries a coincident strobe.
    task automatic finish_pulse(input logic with_strobe, input logic [4:0] pred, input logic [4:0] lab);
        testing_dataset_finished = 1'b1;
        checking_inference       = with_strobe;
        class_inference          = pred;
        true_label               = lab;
        tick();
        testing_dataset_finished = 1'b0;
        checking_inference       = 1'b0;
    endtask

    // Count edges after the finish edge until scoring_done, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!scoring_done && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        nrst = 1'b0; en = 1'b1; start_scoring = 1'b0; checking_inference = 1'b0;
        class_inference = '0; true_label = '0; testing_dataset_finished = 1'b0;
        rd_class = '0;
        #23;
        chk("rst_total", total_count, 0);
        chk("rst_correct", correct_count, 0);
        chk("rst_acc", accuracy_q8, 0);
        chk("rst_flags", {invalid_label, cnt_saturated, scoring_done}, 0);
        @(negedge clk); nrst = 1'b1;
        tick();

        // IDLE ignores strobes and finish pulses
        strobe(5'd1, 5'd1);
        finish_pulse(1'b0, 5'd0, 5'd0);
        tick();
        chk("idle_total", total_count, 0);
        chk("idle_done", scoring_done, 0);

        // 10 strobes, 7 matches -> 179, done on 10th edge
        start_pulse();
        for (int i = 0; i < 10; i++)
            strobe(5'(i), (i < 7) ? 5'(i) : 5'(i + 1));
        finish_pulse(1'b0, 5'd0, 5'd0);
        chk("t1_done_early", scoring_done, 0);
        wait_done(n);
        chk("t1_latency", n, 10);
        chk("t1_total", total_count, 10);
        chk("t1_correct", correct_count, 7);
        chk("t1_acc", accuracy_q8, 179);

        // DONE ignores strobes
        strobe(5'd2, 5'd2);
        chk("done_hold_total", total_count, 10);

        // 4 matching strobes -> 256
        start_pulse();
        chk("clr_done", scoring_done, 0);
        chk("clr_acc", accuracy_q8, 0);
        for (int i = 0; i < 4; i++)
            strobe(5'd9, 5'd9);
        finish_pulse(1'b0, 5'd0, 5'd0);
        wait_done(n);
        chk("t2_acc", accuracy_q8, 256);
        chk("t2_latency", n, 10);

        // Finish with no strobes -> 0, done after 1 edge
        start_pulse();
        chk("t3_acc_cleared", accuracy_q8, 0);
        finish_pulse(1'b0, 5'd0, 5'd0);
        chk("t3_done_1edge", scoring_done, 1);
        chk("t3_acc", accuracy_q8, 0);

        // Invalid label, then strobe coincident with finish
        start_pulse();
        strobe(5'd27, 5'd27);
        chk("inv_flag", invalid_label, 1);
        chk("inv_total", total_count, 0);
        finish_pulse(1'b1, 5'd2, 5'd2);
        chk("coin_total", total_count, 1);
        chk("coin_correct", correct_count, 1);
        wait_done(n);
        chk("coin_latency", n, 10);
        chk("coin_acc", accuracy_q8, 256);
        chk("inv_sticky", invalid_label, 1);

        // Saturation on the 4-bit instance
        start_pulse();
        chk("sat_clr_inv", invalid_label, 0);
        for (int i = 0; i < 20; i++)
            strobe(5'd4, 5'd4);
        chk("sat_total4", s_total, 15);
        chk("sat_correct4", s_correct, 15);
        chk("sat_flag4", s_sat, 1);
        chk("sat_total16", total_count, 20);
        chk("sat_flag16", cnt_saturated, 0);

        // Per-class statistics
        start_pulse();
        strobe(5'd3, 5'd3);
        strobe(5'd1, 5'd3);
        strobe(5'd5, 5'd5);
        chk("pc_global", {total_count, correct_count}, {16'd3, 16'd2});
        rd_class = 5'd3; #1;
`ifdef HDC_PER_CLASS_STATS_EN
        chk("pc3_total", rd_total, 2);
        chk("pc3_correct", rd_correct, 1);
        rd_class = 5'd5; #1;
        chk("pc5_total", rd_total, 1);
        chk("pc5_correct", rd_correct, 1);
`else
        chk("pc3_total", rd_total, 0);
        chk("pc3_correct", rd_correct, 0);
        rd_class = 5'd5; #1;
        chk("pc5_total", rd_total, 0);
        chk("pc5_correct", rd_correct, 0);
`endif
        rd_class = 5'd30; #1;
        chk("pc_oob", {rd_total, rd_correct}, 0);

        // en low for 5 cycles mid-DIV delays done by 5; 1/2 -> 128
        start_pulse();
        strobe(5'd7, 5'd7);
        strobe(5'd6, 5'd7);
        finish_pulse(1'b0, 5'd0, 5'd0);
        n = 0;
        while (!scoring_done && n < 40) begin
            tick();
            n++;
            if (n == 3) en = 1'b0;
            if (n == 8) en = 1'b1;
        end
        en = 1'b1;
        chk("en_latency", n, 15);
        chk("en_acc", accuracy_q8, 128);

        // nrst mid-DIV returns to IDLE with outputs cleared
        start_pulse();
        for (int i = 0; i < 3; i++)
            strobe(5'd8, 5'd8);
        finish_pulse(1'b0, 5'd0, 5'd0);
        repeat (4) tick();
        nrst = 1'b0;
        #2;
        chk("mrst_total", total_count, 0);
        chk("mrst_correct", correct_count, 0);
        chk("mrst_acc_flags", {accuracy_q8, invalid_label, cnt_saturated, scoring_done}, 0);
        @(negedge clk); nrst = 1'b1;
        repeat (12) tick();
        chk("mrst_no_done", scoring_done, 0);
        strobe(5'd8, 5'd8);
        chk("mrst_idle", total_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
